// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage combining the register file, the instruction
// decoder and the ID/EX pipeline register.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   if_valid/if_instr/if_pc   instruction arriving from the IF/ID register
//   wb_en/wb_dest/wb_data     write-back port (bypassed to same-cycle reads)
//   ex_mem_read/ex_dest       load currently in EXE (load-use hazard source)
//   ex_stall                  EXE cannot accept; ID/EX holds its contents
//   ex_flush                  squash the instruction in ID (taken branch)
//   stall_out                 combinational; IF must hold PC and IF/ID
//   id_*                      registered ID/EX outputs, one cycle after IF
module id_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int NUM_REGS = 32,
  parameter bit ZERO_R0  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [PC_W-1:0]   if_pc,
  input  logic              wb_en,
  input  logic [4:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_dest,
  input  logic              ex_stall,
  input  logic              ex_flush,
  output logic              stall_out,
  output logic              id_valid,
  output logic              id_illegal,
  output logic              id_wb_en,
  output logic [1:0]        id_mem_sig,
  output logic [1:0]        id_br_type,
  output logic [3:0]        id_exe_cmd,
  output logic [DATA_W-1:0] id_val1,
  output logic [DATA_W-1:0] id_val2,
  output logic [DATA_W-1:0] id_st_data,
  output logic [PC_W-1:0]   id_pc,
  output logic [4:0]        id_dest
);

  typedef struct packed {
    logic       wb;
    logic [1:0] mem;     // {rd, wr}
    logic [1:0] br;
    logic [3:0] cmd;
    logic       imm;
    logic       legal;
    logic       uses_rs;
    logic       uses_rt;
  } ctrl_t;

  // Register-register ALU op: writes back, reads both sources.
  function automatic ctrl_t alu_r(input logic [3:0] cmd);
    ctrl_t c;
    c         = '0;
    c.wb      = 1'b1;
    c.cmd     = cmd;
    c.legal   = 1'b1;
    c.uses_rs = 1'b1;
    c.uses_rt = 1'b1;
    return c;
  endfunction

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  assign op  = if_instr[31:26];
  assign rs  = if_instr[25:21];
  assign rt  = if_instr[20:16];
  assign rd  = if_instr[15:11];
  assign imm = if_instr[15:0];

  // ---------------- decoder ----------------
  ctrl_t ctrl;
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    ctrl = '0;
    unique case (op)
      6'b000000: ctrl.legal = 1'b1;                       // NOP
      6'b000001: ctrl = alu_r(4'b0000);                   // ADD
      6'b000011: ctrl = alu_r(4'b0010);                   // SUB
      6'b000101: ctrl = alu_r(4'b0100);                   // AND
      6'b000110: ctrl = alu_r(4'b0101);                   // OR
      6'b000111: ctrl = alu_r(4'b0110);                   // NOR
      6'b001000: ctrl = alu_r(4'b0111);                   // XOR
      6'b001001,
      6'b001010: ctrl = alu_r(4'b1000);                   // SLA / SLL
      6'b001011: ctrl = alu_r(4'b1001);                   // SRA
      6'b001100: ctrl = alu_r(4'b1010);                   // SRL
      6'b100000, 6'b100001: begin                         // ADDI / SUBI
        ctrl.wb = 1'b1; ctrl.cmd = op[0] ? 4'b0010 : 4'b0000;
        ctrl.imm = 1'b1; ctrl.legal = 1'b1; ctrl.uses_rs = 1'b1;
      end
      6'b100100: begin                                    // LD
        ctrl.wb = 1'b1; ctrl.mem = 2'b10; ctrl.imm = 1'b1;
        ctrl.legal = 1'b1; ctrl.uses_rs = 1'b1;
      end
      6'b100101: begin                                    // ST
        ctrl.mem = 2'b01; ctrl.imm = 1'b1; ctrl.legal = 1'b1;
        ctrl.uses_rs = 1'b1; ctrl.uses_rt = 1'b1;
      end
      6'b101000: begin                                    // BEZ
        ctrl.br = 2'b01; ctrl.imm = 1'b1; ctrl.legal = 1'b1; ctrl.uses_rs = 1'b1;
      end
      6'b101001: begin                                    // BNE
        ctrl.br = 2'b10; ctrl.imm = 1'b1; ctrl.legal = 1'b1;
        ctrl.uses_rs = 1'b1; ctrl.uses_rt = 1'b1;
      end
      6'b101010: begin                                    // JMP
        ctrl.br = 2'b11; ctrl.imm = 1'b1; ctrl.legal = 1'b1;
      end
      default: ctrl = '0;                                 // illegal: NOP controls
    endcase
  end

  // ---------------- register file ----------------
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok;
  logic [DATA_W-1:0] rs_val, rt_val;

  assign wr_ok = wb_en && (int'(wb_dest) < NUM_REGS) && !(ZERO_R0 && wb_dest == 5'd0);

  // NOTE: the register file is reset like ordinary flops because the decode
  // stage must read zeros after reset; this rules out a RAM macro here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wb_dest] <= wb_data;
    end
  end

  // Reads are combinational; a same-cycle write to the same register is
  // forwarded so the instruction in ID never sees a stale value.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (int'(rs) < NUM_REGS && !(ZERO_R0 && rs == 5'd0))
      rs_val = (wb_en && wb_dest == rs) ? wb_data : regs[rs];
    if (int'(rt) < NUM_REGS && !(ZERO_R0 && rt == 5'd0))
      rt_val = (wb_en && wb_dest == rt) ? wb_data : regs[rt];
  end

  // ---------------- hazard / stall ----------------
  logic hazard;
  assign hazard = if_valid && ex_mem_read && (ex_dest != 5'd0) &&
                  ((ctrl.uses_rs && rs == ex_dest) || (ctrl.uses_rt && rt == ex_dest));
  assign stall_out = hazard || ex_stall;

  logic [DATA_W-1:0] imm_ext;
  assign imm_ext = {{(DATA_W-16){imm[15]}}, imm};

  // ---------------- ID/EX register ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || ex_flush || (!ex_stall && (hazard || !if_valid))) begin
      id_valid   <= 1'b0;
      id_illegal <= 1'b0;
      id_wb_en   <= 1'b0;
      id_mem_sig <= '0;
      id_br_type <= '0;
      id_exe_cmd <= '0;
      id_val1    <= '0;
      id_val2    <= '0;
      id_st_data <= '0;
      id_pc      <= '0;
      id_dest    <= '0;
    end else if (!ex_stall) begin
      id_valid   <= 1'b1;
      id_illegal <= !ctrl.legal;
      id_wb_en   <= ctrl.wb;
      id_mem_sig <= ctrl.mem;
      id_br_type <= ctrl.br;
      id_exe_cmd <= ctrl.cmd;
      id_val1    <= rs_val;
      id_val2    <= ctrl.imm ? imm_ext : rt_val;
      id_st_data <= rt_val;
      id_pc      <= if_pc;
      id_dest    <= ctrl.imm ? rt : rd;
    end
  end

endmodule
